// File: rtl/cu_config_sequencer_if.sv
// Configuration port, compute-unit control and field bus for cu_config_sequencer.
// The slave modport is the sequencer; the master modport is the fabric/unit side.
interface cu_config_sequencer_if #(
  parameter int W  = 7,
  parameter int CW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          abort;
  logic          busy;
  logic          seq_done;
  logic [W-1:0]  result_out;
  logic          cu_config_enable;
  logic          cu_enable;
  logic          cu_done;
  logic [W-1:0]  cu_result;
  logic [W-1:0]  cu_opcode;
  logic [W-1:0]  cu_opA_local;
  logic [W-1:0]  cu_opA_remote;
  logic [W-1:0]  cu_opB_local;
  logic [W-1:0]  cu_opB_remote;
  logic          cu_opA_isLocal;
  logic          cu_opB_isLocal;
  logic          cu_rmux0;
  logic          cu_rmux1;

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, abort, cu_done, cu_result,
    output cfg_ready, busy, seq_done, result_out, cu_config_enable, cu_enable,
           cu_opcode, cu_opA_local, cu_opA_remote, cu_opB_local, cu_opB_remote,
           cu_opA_isLocal, cu_opB_isLocal, cu_rmux0, cu_rmux1
  );

  modport master (
    output cfg_valid, cfg_addr, cfg_data, abort, cu_done, cu_result,
    input  cfg_ready, busy, seq_done, result_out, cu_config_enable, cu_enable,
           cu_opcode, cu_opA_local, cu_opA_remote, cu_opB_local, cu_opB_remote,
           cu_opA_isLocal, cu_opB_isLocal, cu_rmux0, cu_rmux1
  );
endinterface

// File: rtl/cu_config_sequencer.sv
// Configuration-and-run controller for one compute unit: holds the static field
// registers, strobes config once, then keeps the unit enabled for run_count done events.
module cu_config_sequencer #(
  parameter int W  = 7,
  parameter int CW = 8
) (
  input  logic               clk,
  input  logic               reset,
  cu_config_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [W-1:0]  result_q, result_d;
  logic [CW-1:0] run_count_q;
  logic [W-1:0]  opcode_q, opa_local_q, opa_remote_q, opb_local_q, opb_remote_q;
  logic [3:0]    flags_q;
  logic          ready_s;
  logic          accept_s;
  logic [CW-1:0] last_s;

  // Ready is held low during reset and whenever abort is pending.
  assign ready_s  = reset && (state_q == ST_IDLE) && !bus.abort;
  assign accept_s = bus.cfg_valid && ready_s;
  assign last_s   = (run_count_q == {CW{1'b0}}) ? {CW{1'b0}} : (run_count_q - CW'(1));

  // Next-state, iteration counter and result capture.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    result_d = result_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
      iter_d  = {CW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && (bus.cfg_addr == 3'd7)) begin
            state_d = ST_CONFIG;
            iter_d  = {CW{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CONFIG: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.cu_done) begin
            if (iter_q == last_s) begin
              state_d  = ST_DONE;
              result_d = bus.cu_result;
            end else begin
              iter_d = iter_q + CW'(1);
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state, iteration counter and captured result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      iter_q   <= {CW{1'b0}};
      result_q <= {W{1'b0}};
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      result_q <= result_d;
    end
  end

  // Field register file, written only by accepted beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_q     <= {W{1'b0}};
      opa_local_q  <= {W{1'b0}};
      opa_remote_q <= {W{1'b0}};
      opb_local_q  <= {W{1'b0}};
      opb_remote_q <= {W{1'b0}};
      flags_q      <= 4'd0;
      run_count_q  <= {CW{1'b0}};
    end else if (accept_s) begin
      case (bus.cfg_addr)
        3'd0:    opcode_q     <= bus.cfg_data[W-1:0];
        3'd1:    opa_local_q  <= bus.cfg_data[W-1:0];
        3'd2:    opa_remote_q <= bus.cfg_data[W-1:0];
        3'd3:    opb_local_q  <= bus.cfg_data[W-1:0];
        3'd4:    opb_remote_q <= bus.cfg_data[W-1:0];
        3'd5:    flags_q      <= bus.cfg_data[3:0];
        3'd6:    run_count_q  <= bus.cfg_data;
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready        = ready_s;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.seq_done         = (state_q == ST_DONE);
  assign bus.cu_config_enable = (state_q == ST_CONFIG);
  assign bus.cu_enable        = (state_q == ST_RUN);
  assign bus.result_out       = result_q;
  assign bus.cu_opcode        = opcode_q;
  assign bus.cu_opA_local     = opa_local_q;
  assign bus.cu_opA_remote    = opa_remote_q;
  assign bus.cu_opB_local     = opb_local_q;
  assign bus.cu_opB_remote    = opb_remote_q;
  assign bus.cu_opA_isLocal   = flags_q[0];
  assign bus.cu_opB_isLocal   = flags_q[1];
  assign bus.cu_rmux0         = flags_q[2];
  assign bus.cu_rmux1         = flags_q[3];

endmodule
